dht_sensor_reader: RTL
======================

DHT_SENSOR_READER -- requirements
Module: dht_sensor_reader

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency; TICKS_PER_US = CLK_HZ/1_000_000.
REQ-002 SHALL have parameter SENSOR, default 0, sensor mode: 0 = DHT11, 1 = DHT22.
REQ-003 SHALL have parameter START_LOW_US, default 18000, host start-pulse low time in us; DHT22 benches use 1000.
REQ-004 SHALL have parameter BIT1_US, default 40, high-phase threshold in us; strictly above means bit 1.
REQ-005 SHALL have parameter TIMEOUT_US, default 200, maximum duration of any sensor-driven phase in us.
REQ-006 clk  input  1  system clock; all logic on the rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-008 start  input  1  one-cycle read request; accepted only in IDLE.
REQ-009 data  inout  1  single-wire sensor line; the block drives only 0 or 'z; the pull-up is external.
REQ-010 busy  output  1  high from the cycle after start is accepted until DONE.
REQ-011 valid  output  1  one-cycle pulse when a frame passes the checksum.
REQ-012 crc_err  output  1  one-cycle pulse when a frame fails the checksum.
REQ-013 timeout_err  output  1  one-cycle pulse when a phase exceeds TIMEOUT_US.
REQ-014 raw  output  40  last received frame, MSB first; updated on valid or crc_err.
REQ-015 hum  output  16  humidity; updated only on valid.
REQ-016 temp  output  16  temperature, signed two's complement; updated only on valid.

Function
REQ-017 data SHALL be sampled through a 2-flop synchronizer; all edge detection uses the synchronized value, giving 2 cycles of edge latency.
REQ-018 The FSM SHALL use states IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, DONE.
REQ-019 IDLE: line released; start=1 moves to START_LOW and clears the phase counter and bit index.
REQ-020 START_LOW: data driven 0 for START_LOW_US*TICKS_PER_US cycles, then released, then WAIT_RESP.
REQ-021 WAIT_RESP: a synchronized falling edge moves to RESP_LOW.
REQ-022 RESP_LOW: a rising edge moves to RESP_HIGH.
REQ-023 RESP_HIGH: a falling edge moves to BIT_LOW.
REQ-024 BIT_LOW: a rising edge moves to BIT_HIGH and clears the counter.
REQ-025 BIT_HIGH: a falling edge shifts bit (count > BIT1_US*TICKS_PER_US) into the frame LSB, increments the index, then goes to BIT_LOW, or to CHECK after bit 40.
REQ-026 In every state from WAIT_RESP through BIT_HIGH, the phase counter resets on each state change; reaching TIMEOUT_US*TICKS_PER_US pulses timeout_err, releases the line and goes to DONE; raw/hum/temp are unchanged.
REQ-027 Counter width SHALL be $clog2 of max(START_LOW_US, TIMEOUT_US)*TICKS_PER_US + 1; the counter saturates and never wraps.
REQ-028 CHECK (1 cycle): (b0+b1+b2+b3) mod 256 == b4 pulses valid; otherwise it pulses crc_err; raw is loaded either way.
REQ-029 SENSOR=0: hum = {b0,b1}; temp = {b2,b3} unsigned.
REQ-030 SENSOR=1: hum = {b0,b1} in 0.1 %RH; temp = b2[7] ? -{b2[6:0],b3} : {b2[6:0],b3} in 0.1 degC.
REQ-031 DONE (1 cycle) returns to IDLE; busy is low in IDLE; start while busy is ignored with no queuing.
REQ-032 Result pulses SHALL be mutually exclusive; at most one result pulse per accepted start.

Reset
REQ-033 rst=0 SHALL immediately release data ('z) and force IDLE, busy=0, valid=0, crc_err=0, timeout_err=0, raw=0, hum=0, temp=0, synchronizer=1, counter=0, index=0.
REQ-034 Reset mid-frame SHALL discard the partial frame; the first start after release begins a fresh START_LOW.
REQ-035 start coincident with reset release SHALL be ignored.

Verification
REQ-036 SENSOR=0, frame 0x37_00_18_00_4F -> valid pulse, hum=0x3700, temp=0x1800, raw=0x370018004F.
REQ-037 SENSOR=1, START_LOW_US=1000, frame 0x02_8C_80_65_73 -> valid, hum=652, temp=-101 (0xFF9B).
REQ-038 SENSOR=0, frame 0x37_00_18_00_50 -> crc_err pulse, raw=0x3700180050, hum/temp keep prior values.
REQ-039 Sensor never answers after start -> timeout_err exactly 200 us (20000 cycles) after release; busy falls; line stays 'z.
REQ-040 High phases of 40/41 us at 100 MHz (4000/4100 cycles) -> decoded as 0/1 respectively; a second start during busy produces no extra frame.
REQ-041 rst asserted at bit 20 -> data 'z in the same cycle, all outputs 0; a new start then yields a correct valid frame.

Source files
------------

// File: rtl/dht_sensor_reader.sv
// rtl/dht_sensor_reader.sv - single-wire DHT11/DHT22 frame reader
module dht_sensor_reader #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SENSOR       = 0,
  parameter int START_LOW_US = 18000,
  parameter int BIT1_US      = 40,
  parameter int TIMEOUT_US   = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  inout  wire         data,
  output logic        busy,
  output logic        valid,
  output logic        crc_err,
  output logic        timeout_err,
  output logic [39:0] raw,
  output logic [15:0] hum,
  output logic [15:0] temp
);

  localparam int TICKS_PER_US  = CLK_HZ / 1_000_000;
  localparam int START_TICKS   = START_LOW_US * TICKS_PER_US;
  localparam int TIMEOUT_TICKS = TIMEOUT_US * TICKS_PER_US;
  localparam int BIT1_TICKS    = BIT1_US * TICKS_PER_US;
  localparam int MAX_TICKS     = (START_TICKS > TIMEOUT_TICKS) ? START_TICKS : TIMEOUT_TICKS;
  localparam int CNT_W         = $clog2(MAX_TICKS + 1);

  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TICKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W:0]   BIT1_LIM     = (CNT_W + 1)'(BIT1_TICKS);

  typedef enum logic [3:0] {
    IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, DONE
  } state_t;

  state_t           state, state_nx;
  logic [1:0]       sync;
  logic             data_prev;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       bit_idx;
  logic [39:0]      frame;
  logic             fall, rise;
  logic             shift_bit, phase_timeout, sensor_phase;
  logic [CNT_W:0]   hi_len;
  logic [7:0]       sum;
  logic             frame_ok;
  logic [15:0]      temp_mag;
  logic [15:0]      temp_dec;

  // Open-drain: only ever pull low, the external pull-up provides the high level.
  assign data = (state == START_LOW) ? 1'b0 : 1'bz;
  assign busy = (state != IDLE);

  assign fall = data_prev & ~sync[1];
  assign rise = ~data_prev & sync[1];

  // The cycle in which the falling edge is seen still belongs to the high phase.
  assign hi_len = {1'b0, cnt} + 1'b1;

  assign sum      = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
  assign frame_ok = (sum == frame[7:0]);
  assign temp_mag = {1'b0, frame[22:16], frame[15:8]};

  // Temperature decode: DHT22 uses sign-magnitude, DHT11 is plain bytes.
  always_comb begin
    temp_dec = frame[23:8];
    if (SENSOR == 1) begin
      temp_dec = frame[23] ? (16'd0 - temp_mag) : temp_mag;
    end
  end

  // Sensor line synchronizer plus previous-value register for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync      <= 2'b11;
      data_prev <= 1'b1;
    end else begin
      sync      <= {sync[0], data};
      data_prev <= sync[1];
    end
  end

  // Blocks a start that coincides with the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) armed <= 1'b0;
    else      armed <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; a stuck sensor phase overrides to DONE.
  always_comb begin
    state_nx      = state;
    shift_bit     = 1'b0;
    phase_timeout = 1'b0;
    sensor_phase  = 1'b0;
    case (state)
      IDLE:      if (start && armed) state_nx = START_LOW;
      START_LOW: if (cnt == START_LAST) state_nx = WAIT_RESP;
      WAIT_RESP: begin sensor_phase = 1'b1; if (fall) state_nx = RESP_LOW;  end
      RESP_LOW:  begin sensor_phase = 1'b1; if (rise) state_nx = RESP_HIGH; end
      RESP_HIGH: begin sensor_phase = 1'b1; if (fall) state_nx = BIT_LOW;   end
      BIT_LOW:   begin sensor_phase = 1'b1; if (rise) state_nx = BIT_HIGH;  end
      BIT_HIGH: begin
        sensor_phase = 1'b1;
        if (fall) begin
          shift_bit = 1'b1;
          state_nx  = (bit_idx == 6'd39) ? CHECK : BIT_LOW;
        end
      end
      CHECK:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (sensor_phase && (state_nx == state) && (cnt == TIMEOUT_LAST)) begin
      phase_timeout = 1'b1;
      state_nx      = DONE;
    end
  end

  // Phase counter restarts on every state change and saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (state_nx != state) cnt <= '0;
    else if (cnt != CNT_MAX)    cnt <= cnt + 1'b1;
  end

  // Frame shift register and bit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame   <= '0;
      bit_idx <= '0;
    end else if (state == IDLE && state_nx == START_LOW) begin
      frame   <= '0;
      bit_idx <= '0;
    end else if (shift_bit) begin
      frame   <= {frame[38:0], (hi_len > BIT1_LIM)};
      bit_idx <= bit_idx + 1'b1;
    end
  end

  // Result pulses and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid       <= 1'b0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
      raw         <= '0;
      hum         <= '0;
      temp        <= '0;
    end else begin
      valid       <= (state == CHECK) && frame_ok;
      crc_err     <= (state == CHECK) && !frame_ok;
      timeout_err <= phase_timeout;
      if (state == CHECK) begin
        raw <= frame;
        if (frame_ok) begin
          hum  <= frame[39:24];
          temp <= temp_dec;
        end
      end
    end
  end

endmodule
